// File: rtl/servo_cmd_ctrl.sv
// servo_cmd_ctrl: decodes SPI command words into operations on a bank of PWM
// period registers, services debounced button steps on the selected channel,
// and builds the response word the SPI slave shifts out on the next transfer.
module servo_cmd_ctrl #(
  parameter int NUM_CH       = 4,
  parameter int PERIOD_W     = 11,
  parameter int PERIOD_MAX   = 2000,
  parameter int STEP         = 100,
  parameter int RESET_PERIOD = 150
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  rx_word,
  input  logic                         rx_valid,
  input  logic                         btn_up,
  input  logic                         btn_down,
  output logic [NUM_CH*PERIOD_W-1:0]   period,
  output logic [31:0]                  tx_word,
  output logic                         cmd_done,
  output logic                         cmd_error
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic signed [17:0] MAX_S  = 18'(PERIOD_MAX);
  localparam logic signed [17:0] STEP_S = 18'(STEP);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, RESPOND} state_t;
  state_t state;

  logic [31:0]         cmd;
  logic [PERIOD_W-1:0] regs [NUM_CH];
  logic [CW-1:0]       sel_ch;
  logic [7:0]          err_cnt;
  logic [7:0]          overrun_cnt;
  logic                pend_up;
  logic                pend_dn;

  // Decode results registered in DECODE, consumed in EXEC and RESPOND
  logic                err_r;
  logic                clamp_r;
  logic                wr_en_r;
  logic                sel_en_r;
  logic [PERIOD_W-1:0] new_val_r;
  logic [15:0]         rdata_r;

  logic [3:0]          op;
  logic [3:0]          ch;
  logic [7:0]          tag;
  logic [15:0]         data;
  logic [CW-1:0]       ch_idx;

  assign op     = cmd[31:28];
  assign ch     = cmd[27:24];
  assign tag    = cmd[23:16];
  assign data   = cmd[15:0];
  assign ch_idx = cmd[24 +: CW];

  logic                legal;
  logic                dec_clamp;
  logic [PERIOD_W-1:0] dec_val;
  logic [15:0]         dec_rdata;
  logic signed [17:0]  cur_ext;
  logic signed [17:0]  sum;
  logic signed [17:0]  sel_ext;
  logic signed [17:0]  up_ext;
  logic signed [17:0]  dn_ext;
  logic                service;
  logic [PERIOD_W-1:0] btn_val;

  // Command decode, clamped arithmetic and button step value
  always_comb begin
    legal     = (op <= 4'd5) && !((op >= 4'd1) && (op <= 4'd4) && (int'(ch) >= NUM_CH));
    cur_ext   = 18'(regs[ch_idx]);
    sum       = $signed(cur_ext + {{2{data[15]}}, data});
    dec_val   = '0;
    dec_clamp = 1'b0;
    dec_rdata = '0;
    case (op)
      4'd1: begin
        if (32'(data) > PERIOD_MAX) begin
          dec_val   = PERIOD_W'(PERIOD_MAX);
          dec_clamp = 1'b1;
        end else begin
          dec_val = PERIOD_W'(data);
        end
      end
      4'd2: dec_rdata = 16'(regs[ch_idx]);
      4'd4: begin
        if (sum < 0) begin
          dec_val   = '0;
          dec_clamp = 1'b1;
        end else if (sum > MAX_S) begin
          dec_val   = PERIOD_W'(PERIOD_MAX);
          dec_clamp = 1'b1;
        end else begin
          dec_val = PERIOD_W'(sum);
        end
      end
      4'd5: dec_rdata = {overrun_cnt, err_cnt};
      default: ;
    endcase

    service = (state == IDLE) && !rx_valid && (pend_up || pend_dn);
    sel_ext = 18'(regs[sel_ch]);
    up_ext  = sel_ext + STEP_S;
    dn_ext  = sel_ext - STEP_S;
    btn_val = regs[sel_ch];
    if (pend_up && !pend_dn) begin
      btn_val = (up_ext > MAX_S) ? PERIOD_W'(PERIOD_MAX) : PERIOD_W'(up_ext);
    end else if (pend_dn && !pend_up) begin
      btn_val = (dn_ext < 0) ? '0 : PERIOD_W'(dn_ext);
    end
  end

  // Command FSM, period bank, response word and counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cmd         <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) regs[i[CW-1:0]] <= PERIOD_W'(RESET_PERIOD);
      sel_ch      <= '0;
      tx_word     <= '0;
      cmd_done    <= 1'b0;
      cmd_error   <= 1'b0;
      err_cnt     <= '0;
      overrun_cnt <= '0;
      err_r       <= 1'b0;
      clamp_r     <= 1'b0;
      wr_en_r     <= 1'b0;
      sel_en_r    <= 1'b0;
      new_val_r   <= '0;
      rdata_r     <= '0;
    end else begin
      cmd_done  <= 1'b0;
      cmd_error <= 1'b0;
      if (rx_valid && (state != IDLE) && (overrun_cnt != 8'hFF)) overrun_cnt <= overrun_cnt + 8'd1;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            cmd   <= rx_word;
            state <= DECODE;
          end else if (service) begin
            regs[sel_ch] <= btn_val;
          end
        end
        DECODE: begin
          err_r     <= !legal;
          clamp_r   <= legal && dec_clamp;
          wr_en_r   <= legal && ((op == 4'd1) || (op == 4'd4));
          sel_en_r  <= legal && (op == 4'd3);
          new_val_r <= dec_val;
          rdata_r   <= legal ? dec_rdata : '0;
          state     <= EXEC;
        end
        EXEC: begin
          if (wr_en_r) regs[ch_idx] <= new_val_r;
          if (sel_en_r) sel_ch <= ch_idx;
          state <= RESPOND;
        end
        RESPOND: begin
          tx_word   <= err_r ? {4'b1000, ch, tag, 16'h0000}
                             : {1'b0, clamp_r, 2'b00, ch, tag, rdata_r};
          cmd_done  <= 1'b1;
          cmd_error <= err_r;
          if (err_r && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Button pending flags: a pulse on an already-set flag is absorbed
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_up <= 1'b0;
      pend_dn <= 1'b0;
    end else begin
      pend_up <= (pend_up && !service) || (btn_up && !pend_up);
      pend_dn <= (pend_dn && !service) || (btn_down && !pend_dn);
    end
  end

  // Flatten the period bank onto the output bus
  always_comb begin
    period = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) period[i*PERIOD_W +: PERIOD_W] = regs[i[CW-1:0]];
  end

endmodule
